// File: rtl/data_mem_pipe.sv
// Single-port word memory with valid/ready requests, byte enables, a hardware clear sweep and
// a 1- or 2-cycle registered read path. Optional parity storage under `DMEM_PARITY_EN.
`timescale 1ns/1ps

module data_mem_pipe #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned RD_LAT = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  output logic                busy,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_wr,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
`ifdef DMEM_PARITY_EN
  input  logic                err_inj,
`endif
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err
);

  localparam int unsigned NumBytes = DATA_W / 8;

  typedef enum logic [0:0] {StClear, StRun} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic                ptr_last;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic                accept;
  logic                in_range;
  logic                st_en;
  logic                ld_en;
  logic [DATA_W-1:0]   rd_word;
  logic [DATA_W-1:0]   merged;
  logic                rd_err;

  assign ptr_last = (32'(ptr_q) == DEPTH - 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StClear;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    if (clr) begin
      state_d = StClear;
      ptr_d   = '0;
    end else if (state_q == StClear) begin
      if (ptr_last) begin
        state_d = StRun;
        ptr_d   = '0;
      end else begin
        ptr_d = ptr_q + 1'b1;
      end
    end
  end

  assign busy      = (state_q == StClear);
  assign req_ready = (state_q == StRun);

  // A request coinciding with a sampled clr is discarded.
  assign accept   = req_valid & req_ready & ~clr;
  assign in_range = (32'(req_addr) < DEPTH);
  assign st_en    = accept & req_wr & in_range;
  assign ld_en    = accept & ~req_wr;
  assign rd_word  = in_range ? mem[req_addr] : '0;

  always_comb begin
    merged = rd_word;
    for (int i = 0; i < int'(NumBytes); i++) begin
      if (req_be[i]) merged[8*i +: 8] = req_wdata[8*i +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (busy) begin
      mem[ptr_q] <= '0;
    end else if (st_en) begin
      mem[req_addr] <= merged;
    end
  end

`ifdef DMEM_PARITY_EN
  logic mem_par [DEPTH];
  logic rd_par;

  assign rd_par = in_range ? mem_par[req_addr] : 1'b0;
  assign rd_err = ~in_range | (in_range & (rd_par != ^rd_word));

  always_ff @(posedge clk) begin
    if (busy) begin
      mem_par[ptr_q] <= 1'b0;
    end else if (st_en) begin
      mem_par[req_addr] <= (^merged) ^ err_inj;
    end
  end
`else
  assign rd_err = ~in_range;
`endif

  // First read stage: data captured at acceptance, held between loads.
  logic              s0_valid;
  logic [DATA_W-1:0] s0_data;
  logic              s0_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_valid <= 1'b0;
      s0_data  <= '0;
      s0_err   <= 1'b0;
    end else begin
      s0_valid <= ld_en;
      s0_err   <= ld_en & rd_err;
      if (ld_en) s0_data <= rd_word;
    end
  end

  if (RD_LAT == 2) begin : g_lat2
    logic              s1_valid;
    logic [DATA_W-1:0] s1_data;
    logic              s1_err;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s1_valid <= 1'b0;
        s1_data  <= '0;
        s1_err   <= 1'b0;
      end else begin
        s1_valid <= s0_valid;
        s1_err   <= s0_valid & s0_err;
        if (s0_valid) s1_data <= s0_data;
      end
    end

    assign rsp_valid = s1_valid;
    assign rsp_rdata = s1_data;
    assign rsp_err   = s1_err;
  end else begin : g_lat1
    assign rsp_valid = s0_valid;
    assign rsp_rdata = s0_data;
    assign rsp_err   = s0_err;
  end

endmodule

// File: tb/tb_data_mem_pipe.sv
// Directed bench: DUT A (DEPTH=8, RD_LAT=2) and DUT B (DEPTH=6, RD_LAT=1).
`timescale 1ns/1ps

module tb_data_mem_pipe;

  logic clk;
  logic rst_n;

  logic        a_clr, a_busy, a_req_valid, a_req_ready, a_req_wr, a_inj;
  logic [2:0]  a_req_addr;
  logic [15:0] a_req_wdata;
  logic [1:0]  a_req_be;
  logic        a_rsp_valid, a_rsp_err;
  logic [15:0] a_rsp_rdata;

  logic        b_clr, b_busy, b_req_valid, b_req_ready, b_req_wr, b_inj;
  logic [2:0]  b_req_addr;
  logic [15:0] b_req_wdata;
  logic [1:0]  b_req_be;
  logic        b_rsp_valid, b_rsp_err;
  logic [15:0] b_rsp_rdata;

  int pass_cnt  = 0;
  int total_cnt = 0;

  data_mem_pipe #(.DATA_W(16), .DEPTH(8), .ADDR_W(3), .RD_LAT(2)) u_dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (a_clr),
    .busy      (a_busy),
    .req_valid (a_req_valid),
    .req_ready (a_req_ready),
    .req_wr    (a_req_wr),
    .req_addr  (a_req_addr),
    .req_wdata (a_req_wdata),
    .req_be    (a_req_be),
`ifdef DMEM_PARITY_EN
    .err_inj   (a_inj),
`endif
    .rsp_valid (a_rsp_valid),
    .rsp_rdata (a_rsp_rdata),
    .rsp_err   (a_rsp_err)
  );

  data_mem_pipe #(.DATA_W(16), .DEPTH(6), .ADDR_W(3), .RD_LAT(1)) u_dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (b_clr),
    .busy      (b_busy),
    .req_valid (b_req_valid),
    .req_ready (b_req_ready),
    .req_wr    (b_req_wr),
    .req_addr  (b_req_addr),
    .req_wdata (b_req_wdata),
    .req_be    (b_req_be),
`ifdef DMEM_PARITY_EN
    .err_inj   (b_inj),
`endif
    .rsp_valid (b_rsp_valid),
    .rsp_rdata (b_rsp_rdata),
    .rsp_err   (b_rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic a_req(input logic v, input logic wr, input logic [2:0] addr,
                       input logic [15:0] wd, input logic [1:0] be);
    a_req_valid = v;
    a_req_wr    = wr;
    a_req_addr  = addr;
    a_req_wdata = wd;
    a_req_be    = be;
  endtask

  task automatic b_req(input logic v, input logic wr, input logic [2:0] addr,
                       input logic [15:0] wd, input logic [1:0] be);
    b_req_valid = v;
    b_req_wr    = wr;
    b_req_addr  = addr;
    b_req_wdata = wd;
    b_req_be    = be;
  endtask

  task automatic test_reset();
    int na;
    int nb;
    rst_n = 1'b0;
    a_clr = 1'b0;
    b_clr = 1'b0;
    a_inj = 1'b0;
    b_inj = 1'b0;
    a_req(1'b0, 1'b0, 3'd0, 16'h0, 2'b00);
    b_req(1'b0, 1'b0, 3'd0, 16'h0, 2'b00);
    step();
    step();
    total_cnt++;
    if (a_busy !== 1'b1 || a_req_ready !== 1'b0 || a_rsp_valid !== 1'b0 ||
        a_rsp_rdata !== 16'h0 || a_rsp_err !== 1'b0)
      $display("FAIL reset_a: busy=%b ready=%b valid=%b rdata=%h err=%b, want 1 0 0 0000 0",
               a_busy, a_req_ready, a_rsp_valid, a_rsp_rdata, a_rsp_err);
    else pass_cnt++;
    total_cnt++;
    if (b_busy !== 1'b1 || b_req_ready !== 1'b0 || b_rsp_valid !== 1'b0 ||
        b_rsp_rdata !== 16'h0 || b_rsp_err !== 1'b0)
      $display("FAIL reset_b: busy=%b ready=%b valid=%b rdata=%h err=%b, want 1 0 0 0000 0",
               b_busy, b_req_ready, b_rsp_valid, b_rsp_rdata, b_rsp_err);
    else pass_cnt++;
    rst_n = 1'b1;
    na = 0;
    nb = 0;
    for (int k = 0; k < 40; k++) begin
      if (a_busy === 1'b1) na++;
      if (b_busy === 1'b1) nb++;
      step();
    end
    total_cnt++;
    if (na !== 8 || a_req_ready !== 1'b1)
      $display("FAIL sweep_a: busy_cycles=%0d ready=%b, want 8 1", na, a_req_ready);
    else pass_cnt++;
    total_cnt++;
    if (nb !== 6 || b_req_ready !== 1'b1)
      $display("FAIL sweep_b: busy_cycles=%0d ready=%b, want 6 1", nb, b_req_ready);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i <= 8; i++) begin
      a_req(i < 8, 1'b0, 3'(i), 16'h0, 2'b00);
      step();
      total_cnt++;
      if (i == 0) begin
        if (a_rsp_valid !== 1'b0)
          $display("FAIL b2b_lat0: valid=%b, want 0", a_rsp_valid);
        else pass_cnt++;
      end else begin
        if (a_rsp_valid !== 1'b1 || a_rsp_rdata !== 16'h0 || a_rsp_err !== 1'b0)
          $display("FAIL b2b_load%0d: valid=%b rdata=%h err=%b, want 1 0000 0",
                   i - 1, a_rsp_valid, a_rsp_rdata, a_rsp_err);
        else pass_cnt++;
      end
    end
    a_req(1'b0, 1'b0, 3'd0, 16'h0, 2'b00);
    step();
    total_cnt++;
    if (a_rsp_valid !== 1'b0 || a_rsp_err !== 1'b0)
      $display("FAIL b2b_idle: valid=%b err=%b, want 0 0", a_rsp_valid, a_rsp_err);
    else pass_cnt++;
  endtask

  task automatic test_store_load();
    a_req(1'b1, 1'b1, 3'd3, 16'hBEEF, 2'b11);
    step();
    a_req(1'b1, 1'b0, 3'd3, 16'h0, 2'b00);
    step();
    a_req(1'b0, 1'b0, 3'd0, 16'h0, 2'b00);
    total_cnt++;
    if (a_rsp_valid !== 1'b0)
      $display("FAIL sl_early: valid=%b, want 0", a_rsp_valid);
    else pass_cnt++;
    step();
    total_cnt++;
    if (a_rsp_valid !== 1'b1 || a_rsp_rdata !== 16'hBEEF || a_rsp_err !== 1'b0)
      $display("FAIL sl_rsp: valid=%b rdata=%h err=%b, want 1 beef 0",
               a_rsp_valid, a_rsp_rdata, a_rsp_err);
    else pass_cnt++;
    step();
    total_cnt++;
    if (a_rsp_valid !== 1'b0 || a_rsp_rdata !== 16'hBEEF || a_rsp_err !== 1'b0)
      $display("FAIL sl_hold: valid=%b rdata=%h err=%b, want 0 beef 0",
               a_rsp_valid, a_rsp_rdata, a_rsp_err);
    else pass_cnt++;
  endtask

  task automatic test_byte_enable();
    a_req(1'b1, 1'b1, 3'd5, 16'h1234, 2'b11);
    step();
    a_req(1'b1, 1'b1, 3'd5, 16'hAB00, 2'b10);
    step();
    a_req(1'b1, 1'b0, 3'd5, 16'h0, 2'b00);
    step();
    a_req(1'b0, 1'b0, 3'd0, 16'h0, 2'b00);
    step();
    total_cnt++;
    if (a_rsp_valid !== 1'b1 || a_rsp_rdata !== 16'hAB34)
      $display("FAIL be_hi: valid=%b rdata=%h, want 1 ab34", a_rsp_valid, a_rsp_rdata);
    else pass_cnt++;
    a_req(1'b1, 1'b1, 3'd5, 16'hFFFF, 2'b00);
    step();
    a_req(1'b1, 1'b1, 3'd5, 16'h00CD, 2'b01);
    step();
    a_req(1'b1, 1'b0, 3'd5, 16'h0, 2'b00);
    step();
    a_req(1'b0, 1'b0, 3'd0, 16'h0, 2'b00);
    step();
    total_cnt++;
    if (a_rsp_valid !== 1'b1 || a_rsp_rdata !== 16'hABCD)
      $display("FAIL be_lo_noop: valid=%b rdata=%h, want 1 abcd", a_rsp_valid, a_rsp_rdata);
    else pass_cnt++;
  endtask

  task automatic test_out_of_range();
    logic [15:0] exp;
    b_req(1'b1, 1'b1, 3'd6, 16'hFFFF, 2'b11);
    step();
    b_req(1'b1, 1'b0, 3'd6, 16'h0, 2'b00);
    step();
    total_cnt++;
    if (b_rsp_valid !== 1'b1 || b_rsp_rdata !== 16'h0 || b_rsp_err !== 1'b1)
      $display("FAIL oor_load6: valid=%b rdata=%h err=%b, want 1 0000 1",
               b_rsp_valid, b_rsp_rdata, b_rsp_err);
    else pass_cnt++;
    b_req(1'b1, 1'b0, 3'd7, 16'h0, 2'b00);
    step();
    total_cnt++;
    if (b_rsp_valid !== 1'b1 || b_rsp_rdata !== 16'h0 || b_rsp_err !== 1'b1)
      $display("FAIL oor_load7: valid=%b rdata=%h err=%b, want 1 0000 1",
               b_rsp_valid, b_rsp_rdata, b_rsp_err);
    else pass_cnt++;
    b_req(1'b1, 1'b1, 3'd5, 16'h5A5A, 2'b11);
    step();
    for (int i = 0; i < 6; i++) begin
      b_req(1'b1, 1'b0, 3'(i), 16'h0, 2'b00);
      step();
      exp = (i == 5) ? 16'h5A5A : 16'h0000;
      total_cnt++;
      if (b_rsp_valid !== 1'b1 || b_rsp_rdata !== exp || b_rsp_err !== 1'b0)
        $display("FAIL oor_inrange%0d: valid=%b rdata=%h err=%b, want 1 %h 0",
                 i, b_rsp_valid, b_rsp_rdata, b_rsp_err, exp);
      else pass_cnt++;
    end
    b_req(1'b0, 1'b0, 3'd0, 16'h0, 2'b00);
    step();
    total_cnt++;
    if (b_rsp_valid !== 1'b0 || b_rsp_rdata !== 16'h5A5A || b_rsp_err !== 1'b0)
      $display("FAIL oor_hold: valid=%b rdata=%h err=%b, want 0 5a5a 0",
               b_rsp_valid, b_rsp_rdata, b_rsp_err);
    else pass_cnt++;
  endtask

`ifdef DMEM_PARITY_EN
  task automatic test_parity();
    a_inj = 1'b1;
    a_req(1'b1, 1'b1, 3'd1, 16'h0F0F, 2'b11);
    step();
    a_inj = 1'b0;
    a_req(1'b1, 1'b0, 3'd1, 16'h0, 2'b00);
    step();
    a_req(1'b0, 1'b0, 3'd0, 16'h0, 2'b00);
    step();
    total_cnt++;
    if (a_rsp_valid !== 1'b1 || a_rsp_rdata !== 16'h0F0F || a_rsp_err !== 1'b1)
      $display("FAIL par_inj: valid=%b rdata=%h err=%b, want 1 0f0f 1",
               a_rsp_valid, a_rsp_rdata, a_rsp_err);
    else pass_cnt++;
    a_req(1'b1, 1'b1, 3'd1, 16'h0F0F, 2'b11);
    step();
    a_req(1'b1, 1'b0, 3'd1, 16'h0, 2'b00);
    step();
    a_req(1'b0, 1'b0, 3'd0, 16'h0, 2'b00);
    step();
    total_cnt++;
    if (a_rsp_valid !== 1'b1 || a_rsp_rdata !== 16'h0F0F || a_rsp_err !== 1'b0)
      $display("FAIL par_clean: valid=%b rdata=%h err=%b, want 1 0f0f 0",
               a_rsp_valid, a_rsp_rdata, a_rsp_err);
    else pass_cnt++;
  endtask
`endif

  task automatic test_clr_inflight();
    int n;
    a_req(1'b1, 1'b1, 3'd2, 16'h00AA, 2'b11);
    step();
    a_req(1'b1, 1'b0, 3'd2, 16'h0, 2'b00);
    step();
    total_cnt++;
    if (a_rsp_valid !== 1'b0)
      $display("FAIL clr_early: valid=%b, want 0", a_rsp_valid);
    else pass_cnt++;
    a_clr = 1'b1;
    step();
    a_clr = 1'b0;
    total_cnt++;
    if (a_rsp_valid !== 1'b1 || a_rsp_rdata !== 16'h00AA || a_rsp_err !== 1'b0 ||
        a_busy !== 1'b1 || a_req_ready !== 1'b0)
      $display("FAIL clr_inflight: valid=%b rdata=%h err=%b busy=%b ready=%b, want 1 00aa 0 1 0",
               a_rsp_valid, a_rsp_rdata, a_rsp_err, a_busy, a_req_ready);
    else pass_cnt++;
    step();
    total_cnt++;
    if (a_rsp_valid !== 1'b0)
      $display("FAIL clr_discard: valid=%b, want 0", a_rsp_valid);
    else pass_cnt++;
    n = 1;
    while (a_busy === 1'b1 && n < 50) begin
      n++;
      step();
    end
    total_cnt++;
    if (n !== 8 || a_req_ready !== 1'b1 || a_rsp_valid !== 1'b0)
      $display("FAIL clr_sweep: busy_cycles=%0d ready=%b valid=%b, want 8 1 0",
               n, a_req_ready, a_rsp_valid);
    else pass_cnt++;
    step();
    a_req(1'b0, 1'b0, 3'd0, 16'h0, 2'b00);
    total_cnt++;
    if (a_rsp_valid !== 1'b0)
      $display("FAIL clr_held_early: valid=%b, want 0", a_rsp_valid);
    else pass_cnt++;
    step();
    total_cnt++;
    if (a_rsp_valid !== 1'b1 || a_rsp_rdata !== 16'h0000 || a_rsp_err !== 1'b0)
      $display("FAIL clr_held_rsp: valid=%b rdata=%h err=%b, want 1 0000 0",
               a_rsp_valid, a_rsp_rdata, a_rsp_err);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_store_load();
    test_byte_enable();
    test_out_of_range();
`ifdef DMEM_PARITY_EN
    test_parity();
`endif
    test_clr_inflight();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/data_mem_pipe.md
Name: data_mem_pipe

Overview:
- Parametrised successor to the processor's 8x16 data memory.
- Single-port word memory with a valid/ready request interface, per-byte write enables and a configurable read latency of 1 or 2.
- Hardware clear sequencer zeroes the array after reset or on request; out-of-range accesses are flagged.
- Sits between the processor's memory stage and its load write-back path.

Parameters:
DATA_W, 16, word width in bits; must be a multiple of 8
DEPTH, 8, number of words; any value 2..1024, need not be a power of 2
ADDR_W, 3, address width; must satisfy 2**ADDR_W >= DEPTH
RD_LAT, 1, read latency in cycles from request acceptance to rsp_valid; legal values 1 or 2

Ports:
clk  input  1  clock; all state changes on posedge
rst_n  input  1  asynchronous active-low reset
clr  input  1  synchronous pulse; restarts the clear sweep
busy  output  1  high while the clear sweep runs
req_valid  input  1  request present
req_ready  output  1  request can be accepted
req_wr  input  1  1 = store, 0 = load
req_addr  input  ADDR_W  word address
req_wdata  input  DATA_W  store data
req_be  input  DATA_W/8  byte enables; bit i covers bits [8i+7:8i]
rsp_valid  output  1  one-cycle load response strobe
rsp_rdata  output  DATA_W  load data
rsp_err  output  1  response error flag, qualified by rsp_valid

Behaviour:
- Reset (rst_n low, asynchronous): busy=1, req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0. Clear pointer = 0; read pipeline flushed. Array contents are not reset directly.
- FSM states:
  - CLEAR: entered on rst_n release and whenever clr=1 is sampled in any state.
    - Writes 0 to word [ptr] each cycle; ptr runs 0..DEPTH-1.
    - busy=1, req_ready=0.
    - Goes to RUN on the cycle after word DEPTH-1 is written, so the sweep takes exactly DEPTH cycles.
    - clr asserted during CLEAR restarts the sweep at ptr=0.
  - RUN: busy=0, req_ready=1. A request is accepted on a posedge with req_valid & req_ready.
- Store:
  - Committed at the acceptance edge, for bytes with req_be[i]=1 only.
  - req_be=0 is a legal no-op.
  - No response is generated.
- Load:
  - Data is read at the acceptance edge.
  - rsp_valid pulses exactly RD_LAT cycles later, together with rsp_rdata and rsp_err.
  - Back-to-back loads give one response per cycle, in order.
  - A load accepted one cycle after a store to the same address returns the stored data.
- rsp_rdata holds its last value while rsp_valid=0. rsp_err is 0 whenever rsp_valid=0.
- Out of range (req_addr >= DEPTH):
  - Store is dropped; array unchanged.
  - Load returns rsp_rdata=0 with rsp_err=1.
- clr while loads are in flight: those loads still complete with the data captured at acceptance, at their normal timing. The request accepted on the edge where clr is sampled is discarded.
- Requests are not accepted while busy=1. A requester holding req_valid is accepted on the first RUN cycle.

Optional Feature:
- Macro DMEM_PARITY_EN.
- Defined:
  - Each word stores one extra even-parity bit, computed over the full merged word after byte-enable merging.
  - The clear sweep writes parity 0.
  - Extra input port err_inj (1 bit). When err_inj=1 on an accepted store, the inverted parity bit is stored.
  - A load whose recomputed parity mismatches gives rsp_err=1, with the stored data still returned on rsp_rdata.
  - rsp_err = out-of-range OR parity mismatch.
- Undefined: no parity storage, no err_inj port; rsp_err reflects out-of-range only.

Test Plan:
- Release rst_n; no clr -> busy=1 for exactly 8 cycles, then req_ready=1. Loads of addresses 0..7 return 0x0000 with rsp_err=0.
- RD_LAT=2. Store 0xBEEF to address 3 with be=2'b11, then load 3 on the next cycle -> rsp_valid exactly 2 cycles after load acceptance, rsp_rdata=0xBEEF.
- Store 0x1234 to address 5 with be=2'b11, then store 0xAB00 to address 5 with be=2'b10, then load 5 -> 0xAB34.
- DEPTH=6, ADDR_W=3: store 0xFFFF to address 6, then load 6 -> rsp_rdata=0x0000, rsp_err=1. Loads of addresses 0..5 are unchanged.
- RD_LAT=2, address 2 preloaded with 0x00AA: load 2, then pulse clr on the next cycle -> response still 0x00AA at normal timing. busy=1 for 8 cycles; a later load of 2 returns 0x0000.
- DMEM_PARITY_EN: store 0x0F0F to address 1 with err_inj=1, then load 1 -> rsp_rdata=0x0F0F, rsp_err=1. Store again with err_inj=0, then load -> rsp_err=0.
